// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
//   DEFAULT_WIDTH : default operand width in bits
//   state_t       : controller states (IDLE, RUN, DONE)
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder slice used by the serial adder.
//   A, B, Cin : addend bits and carry-in
//   S, Cout   : sum bit and carry-out
module Full_Adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: computes a + b + cin one bit per clock, LSB first,
// through a single full-adder slice.
//   clk, rst     : clock, asynchronous active-high reset
//   start        : begin an addition (only honoured while idle)
//   a, b, cin    : operands, captured on the edge that accepts start
//   busy         : high while bits are being processed
//   done         : one-cycle pulse when the result is ready
//   sum, cout    : result and carry-out, held until the next accepted start
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned          CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s, fa_cout;

  Full_Adder u_fa (
    .A    (a_sr[0]),
    .B    (b_sr[0]),
    .Cin  (carry),
    .S    (fa_s),
    .Cout (fa_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST_BIT) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands shift right so bit i reaches position 0 on the i-th RUN edge;
  // sum bits enter at the MSB so the LSB lands in bit 0 after WIDTH shifts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
          carry  <= fa_cout;
          cnt    <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_sr;
  assign cout = carry;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: an 8-bit and a 4-bit instance,
// directed vectors plus a timing/result model checked every cycle.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic       start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       start4 = 1'b0, cin4 = 1'b0, busy4, done4, cout4;
  logic [3:0] a4 = '0, b4 = '0, sum4;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: an operation accepted at edge k occupies edges k..k+W+1;
  // result = a+b+cin, visible from the done cycle until the next start.
  int          edge_n = 0;
  int          wid[2] = '{8, 4};
  int          k_edge[2];
  bit          active[2];
  logic [31:0] exp_sum[2];
  logic        exp_cout[2];
  bit          inited = 1'b0;
  int          done_edges4[$];

  task automatic model_start(input int id, input logic s, input logic [31:0] a,
                             input logic [31:0] b, input logic c);
    logic [32:0] r;
    if (s && (!active[id] || edge_n >= k_edge[id] + wid[id] + 2)) begin
      r            = {1'b0, a} + {1'b0, b} + {32'b0, c};
      active[id]   = 1'b1;
      k_edge[id]   = edge_n;
      exp_sum[id]  = r[31:0] & ((32'd1 << wid[id]) - 32'd1);
      exp_cout[id] = r[wid[id]];
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < 2; i++) begin
          active[i]   = 1'b0;
          exp_sum[i]  = '0;
          exp_cout[i] = 1'b0;
        end
      end else begin
        edge_n++;
        model_start(0, start8, {24'b0, a8}, {24'b0, b8}, cin8);
        model_start(1, start4, {28'b0, a4}, {28'b0, b4}, cin4);
      end
    end
  end

  task automatic cmp(input int id, input logic busy, input logic done,
                     input logic [31:0] sum, input logic cout);
    int e;
    string tag;
    e   = edge_n - k_edge[id];
    tag = (id == 0) ? "w8" : "w4";
    chk({tag, "_busy"}, busy, active[id] && e < wid[id]);
    chk({tag, "_done"}, done, active[id] && e == wid[id]);
    if (!active[id] || e >= wid[id]) begin
      chk({tag, "_sum"}, sum, exp_sum[id]);
      chk({tag, "_cout"}, cout, exp_cout[id]);
    end
    if (id == 1 && done) done_edges4.push_back(edge_n);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (inited && !rst) begin
        cmp(0, busy8, done8, {24'b0, sum8}, cout8);
        cmp(1, busy4, done4, {28'b0, sum4}, cout4);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Drives one 8-bit operation; optionally pokes start/a during RUN.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input bit disturb, output int lat, output int busy_cnt);
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    @(negedge clk);
    start8   = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    while (!done8 && lat < 40) begin
      if (busy8) busy_cnt++;
      if (disturb && lat == 1) begin start8 = 1'b1; a8 = 8'hFF; end
      if (disturb && lat == 3) start8 = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, bc, bad;
    logic [8:0] v;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    inited = 1'b1;
    chk("reset_busy", busy8, 1'b0);
    chk("reset_done", done8, 1'b0);
    chk("reset_sum", sum8, 8'h00);
    chk("reset_cout", cout8, 1'b0);

    op8(8'h00, 8'h00, 1'b0, 1'b0, lat, bc);
    chk("zero_latency", lat, 8);
    chk("zero_sum", sum8, 8'h00);
    chk("zero_cout", cout8, 1'b0);

    op8(8'hFF, 8'h01, 1'b0, 1'b0, lat, bc);
    chk("ff01_sum", sum8, 8'h00);
    chk("ff01_cout", cout8, 1'b1);

    op8(8'hA5, 8'h5A, 1'b1, 1'b0, lat, bc);
    chk("a55a_sum", sum8, 8'h00);
    chk("a55a_cout", cout8, 1'b1);

    op8(8'hFF, 8'hFF, 1'b1, 1'b0, lat, bc);
    chk("ffff_sum", sum8, 8'hFF);
    chk("ffff_cout", cout8, 1'b1);

    op8(8'h3C, 8'h42, 1'b0, 1'b1, lat, bc);
    chk("ignore_latency", lat, 8);
    chk("ignore_busy_cycles", bc, 8);
    chk("ignore_sum", sum8, 8'h7E);
    chk("ignore_cout", cout8, 1'b0);
    repeat (3) @(negedge clk);
    chk("hold_sum", sum8, 8'h7E);

    // Abort in the 4th RUN cycle with an asynchronous reset.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", busy8, 1'b0);
    chk("abort_done", done8, 1'b0);
    chk("abort_sum", sum8, 8'h00);
    chk("abort_cout", cout8, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    op8(8'h01, 8'h02, 1'b0, 1'b0, lat, bc);
    chk("after_abort_latency", lat, 8);
    chk("after_abort_sum", sum8, 8'h03);
    chk("after_abort_cout", cout8, 1'b0);

    // Exhaustive 4-bit sweep with start held high; operands change mid-run.
    done_edges4.delete();
    @(negedge clk);
    start4 = 1'b1; a4 = '0; b4 = '0; cin4 = 1'b0;
    for (int i = 1; i < 512; i++) begin
      repeat (6) @(negedge clk);
      v = 9'(i);
      a4 = v[8:5]; b4 = v[4:1]; cin4 = v[0];
    end
    @(negedge clk);
    start4 = 1'b0;
    a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
    repeat (8) @(negedge clk);
    chk("sweep_done_count", done_edges4.size(), 512);
    bad = 0;
    for (int i = 1; i < done_edges4.size(); i++)
      if (done_edges4[i] - done_edges4[i-1] != 6) bad++;
    chk("sweep_done_spacing", bad, 0);
    chk("sweep_last_sum", sum4, 4'hF);
    chk("sweep_last_cout", cout4, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
